// File: rtl/test_sv_layer_pkg.sv
// rtl/test_sv_layer_pkg.sv - shared sizes, FSM state type and constant ROM contents
package test_sv_layer_pkg;

  localparam int IN_DIM  = 4;
  localparam int OUT_DIM = 4;
  localparam int DW      = 8;
  localparam int AW      = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Bank 0 is a dense ramp, bank 1 is the identity matrix.
  function automatic logic signed [DW-1:0] w_init(input logic bank, input int o, input int i);
    logic signed [DW-1:0] w;
    if (bank) begin
      w = (o == i) ? DW'(1) : '0;
    end else begin
      w = DW'(o + i + 1);
    end
    return w;
  endfunction

  function automatic logic signed [DW-1:0] x_init(input int i);
    return DW'(i + 1);
  endfunction

endpackage

// File: rtl/test_sv_layer_if.sv
// rtl/test_sv_layer_if.sv - start/select/done control bundle for the layer engine
interface test_sv_layer_if;

  logic sel;
  logic sm_start;
  logic done;

  modport master (output sel, output sm_start, input done);
  modport slave  (input sel, input sm_start, output done);

endinterface

// File: rtl/test_sv_layer_mac_unit.sv
// rtl/test_sv_layer_mac_unit.sv - signed multiply-accumulate, wraps modulo 2^AW
module mac_unit #(
  parameter int DW = 8,
  parameter int AW = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic signed [DW-1:0] a_i,
  input  logic signed [DW-1:0] b_i,
  output logic signed [AW-1:0] acc_o
);

  logic signed [AW-1:0] acc_q;
  logic signed [AW-1:0] acc_d;
  logic signed [AW-1:0] prod;

  always_comb begin
    prod  = AW'(a_i * b_i);
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + prod;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/test_sv_layer.sv
// rtl/test_sv_layer.sv - fully-connected layer engine: FSM, counters, ROMs, output RAM
module test_sv_layer
  import test_sv_layer_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  test_sv_layer_if.slave  bus
);

  localparam int IW = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
  localparam int OW = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;

  state_t               state_q;
  logic                 done_q;
  logic                 bank_q;
  logic [IW-1:0]        i_cnt_q;
  logic [OW-1:0]        o_cnt_q;
  logic signed [AW-1:0] out_mem [OUT_DIM];

  logic                 start_ok;
  logic                 mac_en;
  logic                 mac_clr;
  logic signed [DW-1:0] w_cur;
  logic signed [DW-1:0] x_cur;
  logic signed [AW-1:0] acc;

  // DONE only accepts a new start once done has been visible for a cycle,
  // so a held start still produces a one-cycle done pulse per pass.
  always_comb begin
    start_ok = bus.sm_start && ((state_q == IDLE) || ((state_q == DONE) && done_q));
    mac_en   = (state_q == MAC);
    mac_clr  = start_ok || (state_q == WRITE);
    w_cur    = w_init(bank_q, int'(o_cnt_q), int'(i_cnt_q));
    x_cur    = x_init(int'(i_cnt_q));
  end

  mac_unit #(
    .DW (DW),
    .AW (AW)
  ) u_mac (
    .clk   (clk),
    .reset (reset),
    .clr_i (mac_clr),
    .en_i  (mac_en),
    .a_i   (w_cur),
    .b_i   (x_cur),
    .acc_o (acc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      bank_q  <= 1'b0;
      i_cnt_q <= '0;
      o_cnt_q <= '0;
      for (int k = 0; k < OUT_DIM; k++) begin
        out_mem[k] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            bank_q  <= bus.sel;
            i_cnt_q <= '0;
            o_cnt_q <= '0;
            state_q <= MAC;
          end
        end
        MAC: begin
          i_cnt_q <= i_cnt_q + 1'b1;
          if (i_cnt_q == IW'(IN_DIM - 1)) begin
            state_q <= WRITE;
          end
        end
        WRITE: begin
          out_mem[o_cnt_q] <= acc;
          i_cnt_q          <= '0;
          if (o_cnt_q == OW'(OUT_DIM - 1)) begin
            state_q <= DONE;
          end else begin
            o_cnt_q <= o_cnt_q + 1'b1;
            state_q <= MAC;
          end
        end
        DONE: begin
          if (start_ok) begin
            done_q  <= 1'b0;
            bank_q  <= bus.sel;
            i_cnt_q <= '0;
            o_cnt_q <= '0;
            state_q <= MAC;
          end else begin
            done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.done = done_q;

endmodule

// File: tb/tb_test_sv_layer.sv
// tb/tb_test_sv_layer.sv - directed self-checking bench for the layer engine
module tb_test_sv_layer;
  import test_sv_layer_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  test_sv_layer_if bus ();

  test_sv_layer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_mem(input string tag, input int e0, input int e1, input int e2, input int e3);
    int e [4];
    e = '{e0, e1, e2, e3};
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s_mem%0d", tag, k), 32'(dut.out_mem[k]), 32'(e[k]));
    end
  endtask

  // Launch one pass; optionally disturb sel/sm_start while MAC is running.
  task automatic run_pass(input string tag, input logic s, input bit disturb);
    int lat;
    bus.sel      = s;
    bus.sm_start = 1'b1;
    @(posedge clk);
    #1;
    bus.sm_start = 1'b0;
    check({tag, "_done_drop"}, 32'(bus.done), 32'd0);
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      if (disturb && n == 3) begin
        bus.sm_start = 1'b1;
        bus.sel      = ~s;
      end
      if (disturb && n == 4) begin
        bus.sm_start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        lat = n;
        break;
      end
    end
    bus.sel = s;
    check({tag, "_latency"}, 32'(lat), 32'd21);
  endtask

  initial begin
    int highs;
    int run;
    int max_run;
    bit done_seen;

    reset        = 1'b1;
    bus.sel      = 1'b0;
    bus.sm_start = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_state", 32'(dut.state_q), 32'(IDLE));
    check_mem("rst", 0, 0, 0, 0);

    run_pass("t1", 1'b0, 1'b0);
    check_mem("t1", 30, 40, 50, 60);
    repeat (3) @(posedge clk);
    #1;
    check("t1_done_hold", 32'(bus.done), 32'd1);

    run_pass("t2", 1'b1, 1'b0);
    check_mem("t2", 1, 2, 3, 4);

    run_pass("t3", 1'b0, 1'b1);
    check_mem("t3", 30, 40, 50, 60);

    bus.sel      = 1'b1;
    bus.sm_start = 1'b1;
    @(posedge clk);
    #1;
    bus.sm_start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("t4_partial_mem0", 32'(dut.out_mem[0]), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("t4_done", 32'(bus.done), 32'd0);
    check("t4_state", 32'(dut.state_q), 32'(IDLE));
    check_mem("t4", 0, 0, 0, 0);
    run_pass("t4b", 1'b0, 1'b0);
    check_mem("t4b", 30, 40, 50, 60);

    run_pass("t5", 1'b1, 1'b0);
    check_mem("t5", 1, 2, 3, 4);

    bus.sel      = 1'b0;
    bus.sm_start = 1'b1;
    highs   = 0;
    run     = 0;
    max_run = 0;
    for (int n = 0; n < 50; n++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        highs++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
    end
    bus.sm_start = 1'b0;
    check("held_high_count", 32'(highs), 32'd2);
    check("held_high_width", 32'(max_run), 32'd1);
    check_mem("held", 30, 40, 50, 60);

    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    done_seen = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk);
      #1;
      if (bus.done !== 1'b0) done_seen = 1'b1;
    end
    check("t6_done_quiet", 32'(done_seen), 32'd0);
    check("t6_state", 32'(dut.state_q), 32'(IDLE));
    check_mem("t6", 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
